// File: rtl/des_key_schedule.sv
// ---------------------------------------------------------------------------
// des_key_schedule
//   Iterative DES round-subkey generator. A 64-bit key is passed through PC-1
//   into two 28-bit halves (C, D). The halves are then rotated once per accepted
//   subkey, and PC-2 of the current halves is presented as the round subkey.
//   Encrypt order is K1..K16. Decrypt order is K16..K1, produced by rotating
//   right instead of left, so the Feistel core needs no changes for decryption.
//
// Ports
//   clk_i           system clock, rising edge
//   rst_ni          asynchronous active-low reset (forces IDLE)
//   start_i         begin a new schedule (honoured only in IDLE)
//   decrypt_i       0 = K1..K16, 1 = K16..K1 (sampled with start_i)
//   key_i[63:0]     DES key, bit 63 = FIPS bit 1, parity bits ignored
//   subkey_o[47:0]  current subkey, bit 47 = PC-2 output bit 1
//   subkey_valid_o  subkey_o holds a valid round key
//   subkey_ready_i  consumer accepts subkey_o this cycle
//   round_o[3:0]    FIPS round index of subkey_o minus 1
//   busy_o          schedule in progress
//   done_o          one-cycle pulse after the 16th subkey is accepted
// ---------------------------------------------------------------------------
module des_key_schedule (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        decrypt_i,
    input  logic [63:0] key_i,
    output logic [47:0] subkey_o,
    output logic        subkey_valid_o,
    input  logic        subkey_ready_i,
    output logic [3:0]  round_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    // FIPS 46-3 permutation tables, 1-based FIPS bit numbers
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    state_e      state_q, state_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [3:0]  step_q, step_d;
    logic        mode_q, mode_d;
    logic        done_q, done_d;

    logic [55:0] pc1_w;
    logic [55:0] cd_w;
    logic [47:0] pc2_w;
    logic        last_w;
    logic        one_w;

    function automatic logic [27:0] rotl(input logic [27:0] v, input logic one);
        return one ? {v[26:0], v[27]} : {v[25:0], v[27:26]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] v, input logic one);
        return one ? {v[0], v[27:1]} : {v[1:0], v[27:2]};
    endfunction

    // Pure wiring: FIPS bit b of the key lives at key_i[64-b]
    generate
        for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
            assign pc1_w[55-gi] = key_i[64-PC1_TAB[gi]];
        end
        for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
            assign pc2_w[47-gi] = cd_w[56-PC2_TAB[gi]];
        end
    endgenerate

    assign cd_w   = {c_q, d_q};
    assign last_w = (step_q == 4'd15);

    // Encrypt uses shift(step+2), decrypt uses shift(16-step). Both give a
    // single-bit rotation at exactly steps 0, 7 and 14 (step 15 never rotates).
    assign one_w = (step_q == 4'd0) || (step_q == 4'd7) || (step_q == 4'd14);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_i) state_d = RUN;
            RUN:  if (subkey_ready_i && last_w) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state
    always_comb begin
        c_d    = c_q;
        d_d    = d_q;
        step_d = step_q;
        mode_d = mode_q;
        done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    mode_d = decrypt_i;
                    step_d = 4'd0;
                    if (decrypt_i) begin
                        // C0 equals C16, the starting point for K16
                        c_d = pc1_w[55:28];
                        d_d = pc1_w[27:0];
                    end else begin
                        c_d = rotl(pc1_w[55:28], 1'b1);
                        d_d = rotl(pc1_w[27:0], 1'b1);
                    end
                end
            end
            RUN: begin
                if (subkey_ready_i) begin
                    if (last_w) begin
                        done_d = 1'b1;
                    end else begin
                        step_d = step_q + 4'd1;
                        if (mode_q) begin
                            c_d = rotr(c_q, one_w);
                            d_d = rotr(d_q, one_w);
                        end else begin
                            c_d = rotl(c_q, one_w);
                            d_d = rotl(d_q, one_w);
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            c_q    <= '0;
            d_q    <= '0;
            step_q <= '0;
            mode_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            c_q    <= c_d;
            d_q    <= d_d;
            step_q <= step_d;
            mode_q <= mode_d;
            done_q <= done_d;
        end
    end

    // Output logic
    always_comb begin
        subkey_valid_o = 1'b0;
        busy_o         = 1'b0;
        round_o        = 4'd0;
        if (state_q == RUN) begin
            subkey_valid_o = 1'b1;
            busy_o         = 1'b1;
            round_o        = mode_q ? (4'd15 - step_q) : step_q;
        end
    end

    assign subkey_o = pc2_w;
    assign done_o   = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
module tb_des_key_schedule;

    localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] PARITY  = 64'h0101010101010101;
    localparam logic [47:0] KAT_K1  = 48'h1B02EFFC7072;
    localparam logic [47:0] KAT_K2  = 48'h79AED9DBC9E5;
    localparam logic [47:0] KAT_K16 = 48'hCB3D8B0E17F5;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        decrypt;
    logic [63:0] key;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [3:0]  round;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    logic [47:0] obs  [16];
    logic [47:0] base [16];

    des_key_schedule dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .decrypt_i      (decrypt),
        .key_i          (key),
        .subkey_o       (subkey),
        .subkey_valid_o (subkey_valid),
        .subkey_ready_i (subkey_ready),
        .round_o        (round),
        .busy_o         (busy),
        .done_o         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: Kn = PC2(rotl(C0, S(n)), rotl(D0, S(n))) where S(n) is the
    // cumulative shift total through round n, computed straight from FIPS tables.
    function automatic logic [47:0] ref_subkey(input logic [63:0] k, input int n);
        logic [55:0] cd0;
        logic [55:0] cd;
        logic [27:0] c;
        logic [27:0] d;
        logic [47:0] r;
        int          rot;
        rot = 0;
        for (int i = 0; i < 56; i++) cd0[55-i] = k[64-PC1[i]];
        for (int j = 1; j <= n; j++) rot += (j == 1 || j == 2 || j == 9 || j == 16) ? 1 : 2;
        rot = rot % 28;
        c = cd0[55:28];
        d = cd0[27:0];
        for (int s = 0; s < rot; s++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
        return r;
    endfunction

    // Called at a negedge with the DUT idle (or in its done cycle).
    task automatic run_sched(input logic [63:0] k, input logic dec, input int max_gap,
                             input bit poke_start);
        int hs;
        int cycles;
        int gap;
        int idx;
        logic [47:0] expk [16];
        for (int n = 1; n <= 16; n++) expk[n-1] = ref_subkey(k, n);
        start   = 1'b1;
        key     = k;
        decrypt = dec;
        subkey_ready = 1'b0;
        @(negedge clk);
        start   = 1'b0;
        key     = {$urandom, $urandom};
        decrypt = ~dec;
        hs      = 0;
        cycles  = 0;
        gap     = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
        while (hs < 16 && cycles < 200) begin
            idx = dec ? 15 - hs : hs;
            check_eq("valid", subkey_valid, 1);
            check_eq("busy", busy, 1);
            check_eq("done_low", done, 0);
            check_eq("subkey", subkey, expk[idx]);
            check_eq("round", round, idx);
            obs[hs] = subkey;
            if (poke_start) begin
                start = $urandom_range(0, 1);
                key   = {$urandom, $urandom};
            end
            if (gap == 0) begin
                subkey_ready = 1'b1;
                $display("hs %0d dec %0d round %0d subkey %h", hs, dec, round, subkey);
                hs++;
                gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            end else begin
                subkey_ready = $urandom_range(0, 1) == 0 ? 1'b0 : 1'b0;
                gap--;
            end
            @(negedge clk);
            cycles++;
        end
        check_eq("handshakes", hs, 16);
        if (max_gap == 0) check_eq("cycles", cycles, 16);
        subkey_ready = 1'b0;
        start = 1'b0;
        check_eq("done_pulse", done, 1);
        check_eq("valid_done", subkey_valid, 0);
        check_eq("busy_done", busy, 0);
    endtask

    initial begin
        logic [63:0] rk;
        rst_n        = 1'b0;
        start        = 1'b0;
        decrypt      = 1'b0;
        key          = '0;
        subkey_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", subkey_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_round", round, 0);
        check_eq("rst_subkey", subkey, 0);
        rst_n = 1'b1;

        // Ready while idle must not start anything
        subkey_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle_valid", subkey_valid, 0);
        subkey_ready = 1'b0;

        // Encrypt, full throughput, known answers
        run_sched(KAT_KEY, 1'b0, 0, 1'b0);
        check_eq("kat_k1", obs[0], KAT_K1);
        check_eq("kat_k2", obs[1], KAT_K2);
        check_eq("kat_k16", obs[15], KAT_K16);
        for (int i = 0; i < 16; i++) base[i] = obs[i];

        // Decrypt back-to-back from the done cycle
        run_sched(KAT_KEY, 1'b1, 0, 1'b0);
        check_eq("dec_first", obs[0], KAT_K16);
        check_eq("dec_last", obs[15], KAT_K1);
        for (int i = 0; i < 16; i++) check_eq("dec_reverse", obs[i], base[15-i]);

        // Parity bits ignored
        run_sched(KAT_KEY ^ PARITY, 1'b0, 0, 1'b0);
        for (int i = 0; i < 16; i++) check_eq("parity", obs[i], base[i]);

        // Stalls and start pokes during RUN, random keys, both modes
        for (int t = 0; t < 6; t++) begin
            rk = {$urandom, $urandom};
            run_sched(rk, t[0], 5, 1'b1);
            @(negedge clk);
            check_eq("done_one_cycle", done, 0);
        end
        run_sched(KAT_KEY, 1'b1, 5, 1'b1);

        // Reset asserted mid-schedule at step 7
        start   = 1'b1;
        key     = KAT_KEY;
        decrypt = 1'b0;
        @(negedge clk);
        start        = 1'b0;
        subkey_ready = 1'b1;
        repeat (7) @(negedge clk);
        check_eq("pre_rst_round", round, 7);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_valid", subkey_valid, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_round", round, 0);
        check_eq("arst_subkey", subkey, 0);
        check_eq("arst_done", done, 0);
        @(negedge clk);
        rst_n        = 1'b1;
        subkey_ready = 1'b0;
        @(negedge clk);
        check_eq("post_rst_valid", subkey_valid, 0);
        run_sched(KAT_KEY, 1'b0, 0, 1'b0);
        check_eq("post_rst_k1", obs[0], KAT_K1);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case the run never reaches its summary
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/des_key_schedule.md
# des_key_schedule

Iterative DES round-subkey generator for the encryption engine datapath. It accepts a 64-bit key, applies PC-1, and delivers the sixteen 48-bit PC-2 subkeys one per handshake. Order is K1..K16 for encryption and K16..K1 for decryption, so the decrypt path reuses the round datapath unchanged. It sits between the wrapper's key register and the Feistel round core.

## Interface
- No parameters; all widths are fixed by FIPS 46-3.
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low; 0 forces IDLE immediately.
- start  in  1  request a new schedule; honoured only in IDLE.
- decrypt  in  1  0 = K1..K16 order, 1 = K16..K1 order; sampled with start.
- key  in  64  DES key; bit 63 = FIPS bit 1; parity bits (8,16,...,64) ignored.
- subkey  out  48  current subkey; bit 47 = PC-2 output bit 1.
- subkey_valid  out  1  subkey holds a valid round key.
- subkey_ready  in  1  consumer accepts subkey this cycle.
- round  out  4  FIPS round index of subkey minus 1 (0 = K1 ... 15 = K16).
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the 16th subkey is accepted.

## Operation
- Registers: C[27:0] and D[27:0] (PC-1 halves), a 4-bit step counter, a mode flag, and a 2-state FSM (IDLE, RUN).
- shift(r) = 1 for r in {1,2,9,16}, else 2. Total shift is 28, so C16 = C0 and D16 = D0.
- subkey = PC2(C,D). It is a combinational function of registered C and D, with no extra register stage.
- IDLE with start=1:
  - Load C,D from PC1(key).
  - Encrypt: additionally rotate left by 1, giving C1,D1.
  - Decrypt: no rotation, giving C0 = C16.
  - Latch decrypt into the mode flag, clear step, go to RUN.
- RUN:
  - subkey_valid=1, busy=1.
  - round = step in encrypt mode and 15-step in decrypt mode.
  - Handshake is subkey_valid & subkey_ready.
  - On a handshake with step<15:
    - Encrypt: rotate C,D left by shift(step+2).
    - Decrypt: rotate C,D right by shift(16-step).
    - Increment step.
  - On a handshake with step=15: go to IDLE and pulse done for 1 cycle. C,D keep their value.
  - No handshake: C, D, step, subkey and round hold (stall of any length).
- start is ignored while in RUN. The decrypt and key inputs are don't-care outside the start cycle.
- In IDLE: subkey_valid=0 and busy=0. subkey shows PC2 of the held C,D, and the consumer must ignore it.

## Timing
- Reset values: subkey_valid=0, busy=0, done=0, round=0, subkey=0 (C=D=0), FSM=IDLE.
- Latency: start high at edge N puts the first subkey valid in cycle N+1.
- Throughput: with subkey_ready held at 1, one subkey per cycle. All 16 subkeys occupy cycles N+1..N+16.
- done=1 in cycle N+17; subkey_valid=0 in that cycle.
- A new start may be accepted in the same cycle done is high (FSM is IDLE), giving back-to-back schedules with a 1-cycle gap.
- Reset mid-RUN: outputs go to reset values asynchronously. The next start begins a fresh schedule; no partial state survives.
- subkey_ready while not valid has no effect.
- start and reset release in the same cycle: start is ignored until the first edge at which reset=1.

## Test plan
- Encrypt, key 0x133457799BBCDFF1, ready=1:
  - Cycle N+1: subkey=0x1B02EFFC7072, round=0.
  - Cycle N+2: subkey=0x79AED9DBC9E5, round=1.
  - Cycle N+16: subkey=0xCB3D8B0E17F5, round=15.
  - Cycle N+17: done pulse.
- Decrypt, same key: first subkey 0xCB3D8B0E17F5 with round=15; last 0x1B02EFFC7072 with round=0. The full 16-entry sequence is the exact reverse of the encrypt run.
- Random subkey_ready gaps (0-5 cycles) in both modes: the sequence matches the no-stall run, subkey and round are stable while stalled, and the handshake count is exactly 16.
- start pulsed during RUN with a different key: the sequence is unchanged. start in the done cycle: a new schedule starts and its first subkey appears the next cycle.
- reset driven low mid-schedule at step 7: outputs zero in the same cycle without waiting for an edge. After release and start, K1 appears correctly.
- Key 0x133457799BBCDFF1 with all parity bits flipped (XOR 0x0101010101010101): subkeys are identical to the unflipped run.
